// File: rtl/calc_seq_ctrl.sv
// rtl/calc_seq_ctrl.sv - calculator sequencing controller
//
// Purpose:
//   The controller detects rising edges on the nine front-panel button levels.
//   It builds two two-digit decimal operands from the digit buttons.
//   On an operation button it runs the shared arithmetic unit, then the
//   binary-to-BCD converter, using start/done handshakes for both.
//   It latches the display digits and the dot, neg and err flags.
//
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   b1_i..b9_i       button levels
//                    b1/b2 step A tens/units, b3/b4 step B tens/units
//                    b5 add, b6 sub, b7 mul, b8 div, b9 concat
//   op_a_o, op_b_o   operands, binary 0..99
//   op_code_o        0 add, 1 sub, 2 mul, 3 div, 4 concat
//   alu_start_o      start pulse to the arithmetic unit
//   alu_done_i       completion pulse from the arithmetic unit
//   alu_result_i     arithmetic result
//   bcd_bin_o        value presented to the converter
//   bcd_start_o      start pulse to the converter
//   bcd_done_i       completion pulse from the converter
//   bcd_digits_i     converter output
//   disp_bcd_o       latched display digits
//   dot_o            decimal point enable
//   neg_o            result is negative
//   err_o            divide-by-zero or timeout
//   busy_o           an operation is in flight

module calc_seq_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        b1_i,
  input  logic        b2_i,
  input  logic        b3_i,
  input  logic        b4_i,
  input  logic        b5_i,
  input  logic        b6_i,
  input  logic        b7_i,
  input  logic        b8_i,
  input  logic        b9_i,
  output logic [6:0]  op_a_o,
  output logic [6:0]  op_b_o,
  output logic [2:0]  op_code_o,
  output logic        alu_start_o,
  input  logic        alu_done_i,
  input  logic [16:0] alu_result_i,
  output logic [16:0] bcd_bin_o,
  output logic        bcd_start_o,
  input  logic        bcd_done_i,
  input  logic [15:0] bcd_digits_i,
  output logic [15:0] disp_bcd_o,
  output logic        dot_o,
  output logic        neg_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_CAT = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_CONV = 2'd2,
    S_SHOW = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [8:0]    btn, btn_q, press;
  logic          digit_press, op_press, accept;
  logic [3:0]    a_t_q, a_u_q, b_t_q, b_u_q;
  logic [6:0]    a_val, b_val;
  logic [2:0]    op_sel;
  logic          swap, div0, timeout_hit;
  logic [CW-1:0] cnt_q;
  logic [6:0]    op_a_q, op_b_q;
  logic [2:0]    op_code_q;
  logic [16:0]   bcd_bin_q;
  logic [15:0]   disp_q;
  logic          dot_q, neg_q, err_q;

  function automatic logic [3:0] inc_digit(input logic [3:0] d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  assign btn         = {b9_i, b8_i, b7_i, b6_i, b5_i, b4_i, b3_i, b2_i, b1_i};
  assign press       = btn & ~btn_q;
  assign digit_press = |press[3:0];
  assign op_press    = |press[8:4];
  assign accept      = (state_q == S_IDLE) || (state_q == S_SHOW);

  assign a_val = 7'(a_t_q) * 7'd10 + 7'(a_u_q);
  assign b_val = 7'(b_t_q) * 7'd10 + 7'(b_u_q);

  // Lowest-numbered operation button wins when several land together.
  always_comb begin
    op_sel = OP_CAT;
    if (press[4])      op_sel = OP_ADD;
    else if (press[5]) op_sel = OP_SUB;
    else if (press[6]) op_sel = OP_MUL;
    else if (press[7]) op_sel = OP_DIV;
  end

  // Decisions use the digit registers directly.
  // op_a_q/op_b_q lag the digits by one cycle.
  assign swap        = (op_sel == OP_SUB) && (a_val < b_val);
  assign div0        = (op_sel == OP_DIV) && (b_val == 7'd0);
  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_SHOW: begin
        if (op_press)                          state_d = div0 ? S_SHOW : S_CALC;
        else if (digit_press && state_q == S_SHOW) state_d = S_IDLE;
      end
      S_CALC: begin
        if (alu_done_i)       state_d = S_CONV;
        else if (timeout_hit) state_d = S_SHOW;
      end
      S_CONV: begin
        if (bcd_done_i)       state_d = S_SHOW;
        else if (timeout_hit) state_d = S_SHOW;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state.
  // The count is zero only in the first cycle after entering CALC or CONV.
  always_comb begin
    busy_o      = 1'b0;
    alu_start_o = 1'b0;
    bcd_start_o = 1'b0;
    unique case (state_q)
      S_CALC: begin
        busy_o      = 1'b1;
        alu_start_o = (cnt_q == '0);
      end
      S_CONV: begin
        busy_o      = 1'b1;
        bcd_start_o = (cnt_q == '0);
      end
      default: ;
    endcase
  end

  // Any state change restarts the wait counter.
  // This covers entry into CALC and entry into CONV.
  always_ff @(posedge clk_i) begin
    if (rst_i)                  cnt_q <= '0;
    else if (state_d != state_q) cnt_q <= '0;
    else if (busy_o)             cnt_q <= cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      btn_q     <= '0;
      a_t_q     <= '0;
      a_u_q     <= '0;
      b_t_q     <= '0;
      b_u_q     <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      op_code_q <= OP_ADD;
      bcd_bin_q <= '0;
      disp_q    <= '0;
      dot_q     <= 1'b0;
      neg_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // Edge history tracks the buttons even while busy.
      // A button held through an operation therefore does not fire afterwards.
      btn_q <= btn;
      unique case (state_q)
        S_IDLE, S_SHOW: begin
          if (op_press) begin
            op_code_q <= op_sel;
            op_a_q    <= swap ? b_val : a_val;
            op_b_q    <= swap ? a_val : b_val;
            neg_q     <= swap;
            err_q     <= div0;
            dot_q     <= div0;
            if (div0) disp_q <= '0;
          end else begin
            if (press[0]) a_t_q <= inc_digit(a_t_q);
            if (press[1]) a_u_q <= inc_digit(a_u_q);
            if (press[2]) b_t_q <= inc_digit(b_t_q);
            if (press[3]) b_u_q <= inc_digit(b_u_q);
            op_a_q <= a_val;
            op_b_q <= b_val;
            if (digit_press && state_q == S_SHOW) begin
              dot_q <= 1'b0;
              neg_q <= 1'b0;
              err_q <= 1'b0;
            end
          end
        end
        S_CALC: begin
          if (alu_done_i) begin
            bcd_bin_q <= alu_result_i;
          end else if (timeout_hit) begin
            err_q  <= 1'b1;
            disp_q <= '0;
            dot_q  <= (op_code_q != OP_CAT);
          end
        end
        S_CONV: begin
          if (bcd_done_i) begin
            disp_q <= bcd_digits_i;
            dot_q  <= (op_code_q != OP_CAT);
          end else if (timeout_hit) begin
            err_q  <= 1'b1;
            disp_q <= '0;
            dot_q  <= (op_code_q != OP_CAT);
          end
        end
        default: ;
      endcase
    end
  end

  assign op_a_o     = op_a_q;
  assign op_b_o     = op_b_q;
  assign op_code_o  = op_code_q;
  assign bcd_bin_o  = bcd_bin_q;
  assign disp_bcd_o = disp_q;
  assign dot_o      = dot_q;
  assign neg_o      = neg_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// tb/tb_calc_seq_ctrl.sv - directed-vector bench for calc_seq_ctrl

module tb_calc_seq_ctrl;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  btn;
  logic [6:0]  op_a, op_b;
  logic [2:0]  op_code;
  logic        alu_start, alu_done;
  logic [16:0] alu_result;
  logic [16:0] bcd_bin;
  logic        bcd_start, bcd_done;
  logic [15:0] bcd_digits;
  logic [15:0] disp_bcd;
  logic        dot, neg, err, busy;

  int n_vec  = 0;
  int n_miss = 0;
  int n_alu  = 0;
  int n0;

  always #5 clk = ~clk;

  always @(posedge clk) if (alu_start === 1'b1) n_alu <= n_alu + 1;

  calc_seq_ctrl #(.TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .b1_i(btn[0]), .b2_i(btn[1]), .b3_i(btn[2]), .b4_i(btn[3]), .b5_i(btn[4]),
    .b6_i(btn[5]), .b7_i(btn[6]), .b8_i(btn[7]), .b9_i(btn[8]),
    .op_a_o(op_a), .op_b_o(op_b), .op_code_o(op_code),
    .alu_start_o(alu_start), .alu_done_i(alu_done), .alu_result_i(alu_result),
    .bcd_bin_o(bcd_bin), .bcd_start_o(bcd_start), .bcd_done_i(bcd_done),
    .bcd_digits_i(bcd_digits), .disp_bcd_o(disp_bcd),
    .dot_o(dot), .neg_o(neg), .err_o(err), .busy_o(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_btn(input int idx, input int n);
    repeat (n) begin
      btn[idx] = 1'b1;
      cyc(1);
      btn[idx] = 1'b0;
      cyc(1);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1; btn = '0; alu_done = 1'b0; bcd_done = 1'b0;
    alu_result = '0; bcd_digits = '0;
    cyc(2);
    rst = 1'b0;
  endtask

  // Full operation with 1-cycle responders; checks handshake timing on the way.
  task automatic op_cycle(input int bit_i, input logic [16:0] res, input logic [15:0] dig,
                          input logic [2:0] code, input logic [6:0] ea, input logic [6:0] eb);
    int s0;
    s0 = n_alu;
    btn[bit_i] = 1'b1;
    cyc(1);
    check("alu_start_first", alu_start, 1);
    check("op_code", op_code, code);
    check("op_a_calc", op_a, ea);
    check("op_b_calc", op_b, eb);
    btn[bit_i] = 1'b0;
    cyc(1);
    check("alu_start_second", alu_start, 0);
    alu_done = 1'b1; alu_result = res;
    cyc(1);
    alu_done = 1'b0;
    check("bcd_start", bcd_start, 1);
    check("bcd_bin", bcd_bin, res);
    bcd_done = 1'b1; bcd_digits = dig;
    cyc(1);
    bcd_done = 1'b0;
    check("busy_show", busy, 0);
    check("disp_bcd", disp_bcd, dig);
    check("alu_start_count", n_alu - s0, 1);
  endtask

  initial begin
    // Reset values
    do_reset;
    check("rst_op_a", op_a, 0);
    check("rst_op_b", op_b, 0);
    check("rst_op_code", op_code, 0);
    check("rst_disp", disp_bcd, 0);
    check("rst_flags", {dot, neg, err, busy, alu_start, bcd_start}, 0);
    check("rst_bcd_bin", bcd_bin, 0);

    // Add 34 + 12
    press_btn(0, 3); press_btn(1, 4); press_btn(2, 1); press_btn(3, 2);
    check("add_op_a", op_a, 34);
    check("add_op_b", op_b, 12);
    op_cycle(4, 17'd46, 16'h0046, 3'd0, 7'd34, 7'd12);
    check("add_dot", dot, 1);
    check("add_err", err, 0);
    check("add_neg", neg, 0);

    // Digit wrap and held button
    do_reset;
    press_btn(1, 12);
    check("wrap_op_a", op_a, 2);
    btn[1] = 1'b1;
    cyc(10);
    btn[1] = 1'b0;
    cyc(1);
    check("hold_op_a", op_a, 3);

    // Sub 5 - 20 swaps operands
    do_reset;
    press_btn(1, 5); press_btn(2, 2);
    check("sub_op_b_pre", op_b, 20);
    op_cycle(5, 17'd15, 16'h0015, 3'd1, 7'd20, 7'd5);
    check("sub_neg", neg, 1);
    check("sub_dot", dot, 1);
    btn[0] = 1'b1;
    cyc(1);
    check("sub_exit_neg", neg, 0);
    check("sub_exit_dot", dot, 0);
    check("sub_exit_disp_hold", disp_bcd, 16'h0015);
    btn[0] = 1'b0;
    cyc(1);
    check("sub_exit_op_a", op_a, 15);
    check("sub_exit_op_b", op_b, 20);

    // Divide by zero: B 20 -> 0 by wrapping tens
    press_btn(2, 8);
    check("div0_op_b", op_b, 0);
    n0 = n_alu;
    btn[7] = 1'b1;
    cyc(1);
    check("div0_err", err, 1);
    check("div0_disp", disp_bcd, 0);
    check("div0_dot", dot, 1);
    check("div0_busy", busy, 0);
    check("div0_op_code", op_code, 3);
    btn[7] = 1'b0;
    cyc(3);
    check("div0_no_start", n_alu - n0, 0);
    check("div0_err_hold", err, 1);

    // Div 99 / 9
    do_reset;
    press_btn(0, 9); press_btn(1, 9); press_btn(3, 9);
    op_cycle(7, 17'd11, 16'h0011, 3'd3, 7'd99, 7'd9);
    check("div_err", err, 0);
    check("div_dot", dot, 1);

    // Simultaneous b6+b9+b1; presses during CALC ignored, held buttons stay quiet
    do_reset;
    n0 = n_alu;
    btn = 9'b1_0010_0001;
    cyc(1);
    check("prio_op_code", op_code, 1);
    check("prio_busy", busy, 1);
    btn = '0;
    cyc(1);
    btn[2] = 1'b1; btn[4] = 1'b1;
    cyc(1);
    check("calc_press_op_code", op_code, 1);
    check("calc_press_start", alu_start, 0);
    alu_done = 1'b1; alu_result = '0;
    cyc(1);
    alu_done = 1'b0;
    bcd_done = 1'b1; bcd_digits = '0;
    cyc(1);
    bcd_done = 1'b0;
    cyc(2);
    check("held_busy", busy, 0);
    btn = '0;
    cyc(1);
    check("prio_op_a", op_a, 0);
    check("held_op_b", op_b, 0);
    check("prio_start_count", n_alu - n0, 1);

    // Timeout waiting for alu_done
    do_reset;
    press_btn(1, 1);
    btn[4] = 1'b1;
    cyc(1);
    btn[4] = 1'b0;
    check("to_start", alu_start, 1);
    cyc(TO - 1);
    check("to_err_early", err, 0);
    check("to_busy_early", busy, 1);
    cyc(1);
    check("to_err", err, 1);
    check("to_busy", busy, 0);
    check("to_disp", disp_bcd, 0);
    check("to_dot", dot, 1);

    // Reset during CONV, then a stray done
    do_reset;
    press_btn(1, 2);
    btn[4] = 1'b1;
    cyc(1);
    btn[4] = 1'b0;
    alu_done = 1'b1; alu_result = 17'd2;
    cyc(1);
    alu_done = 1'b0;
    check("conv_bcd_start", bcd_start, 1);
    rst = 1'b1;
    cyc(1);
    check("midrst_busy", busy, 0);
    check("midrst_op_a", op_a, 0);
    check("midrst_bcd_bin", bcd_bin, 0);
    check("midrst_bcd_start", bcd_start, 0);
    rst = 1'b0;
    bcd_done = 1'b1; bcd_digits = 16'h1234;
    cyc(1);
    bcd_done = 1'b0;
    check("stray_disp", disp_bcd, 0);
    check("stray_flags", {dot, err, busy}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
